// File: rtl/alu_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_chk_pkg
//  Purpose  : Shared definitions for the ALU result checker: opcode
//             encodings, sticky error-flag bit positions and the reference
//             model of the ALU used to predict every result.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_chk_pkg;

    // Widest operand the reference model supports. Callers size-cast the
    // result down to their own 2*DATA_WIDTH.
    localparam int c_MAX_DW = 32;

    // ALU opcodes
    localparam logic [1:0] c_SEL_ADD = 2'b00;
    localparam logic [1:0] c_SEL_SUB = 2'b01;
    localparam logic [1:0] c_SEL_INC = 2'b10;
    localparam logic [1:0] c_SEL_NOP = 2'b11;

    // Bit positions inside err_flags_o
    localparam int c_ERR_MISMATCH   = 0;
    localparam int c_ERR_UNEXPECTED = 1;
    localparam int c_ERR_OVERFLOW   = 2;
    localparam int c_ERR_TIMEOUT    = 3;

    // Expected ALU result, evaluated in 2*dw bits (carry kept, subtraction
    // wraps modulo 2^(2*dw)). Bits above 2*dw are forced to zero.
    function automatic logic [2*c_MAX_DW-1:0] alu_exp_result(
        input logic [c_MAX_DW-1:0] op1,
        input logic [c_MAX_DW-1:0] op2,
        input logic [1:0]          sel,
        input int unsigned         dw
    );
        logic [2*c_MAX_DW-1:0] a;
        logic [2*c_MAX_DW-1:0] b;
        logic [2*c_MAX_DW-1:0] r;
        logic [2*c_MAX_DW-1:0] mask;
        a    = (2*c_MAX_DW)'(op1);
        b    = (2*c_MAX_DW)'(op2);
        mask = {(2*c_MAX_DW){1'b1}} >> (2*c_MAX_DW - 2*dw);
        case (sel)
            c_SEL_ADD: r = a + b;
            c_SEL_SUB: r = a - b;
            c_SEL_INC: r = a + 1'b1;
            c_SEL_NOP: r = '0;
            default:   r = '0;
        endcase
        return r & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_checker_if
//  Purpose  : Snoop bundle between the ALU harness and the result checker:
//             the request issued to the ALU and the response it returns.
//  Modports : master - drives request/response (ALU side / harness)
//             slave  - observes request/response (checker)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_result_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
);
    logic                    req_valid_i;
    logic [DATA_WIDTH-1:0]   req_data_1_i;
    logic [DATA_WIDTH-1:0]   req_data_2_i;
    logic [SEL_WIDTH-1:0]    req_sel_i;
    logic                    rsp_valid_i;
    logic [2*DATA_WIDTH-1:0] rsp_data_i;

    modport master (
        output req_valid_i, req_data_1_i, req_data_2_i, req_sel_i,
        output rsp_valid_i, rsp_data_i
    );

    modport slave (
        input req_valid_i, req_data_1_i, req_data_2_i, req_sel_i,
        input rsp_valid_i, rsp_data_i
    );
endinterface
`default_nettype wire

// File: rtl/alu_chk_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_chk_fifo
//  Purpose  : Synchronous FIFO holding expected results in issue order.
//             Pointers carry an extra wrap bit so full and empty are told
//             apart without an occupancy counter.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             i_push, i_wdata   - write at tail (caller never pushes a full
//                                 FIFO unless it pops in the same cycle)
//             i_pop             - drop head (caller never pops when empty)
//             o_full, o_empty   - occupancy status
//             o_head            - oldest entry
//  Revision : 1.0 - initial release
// ============================================================================
module alu_chk_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head
);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_checker
//  Purpose  : Snoops ALU requests, predicts each result, queues predictions
//             in order and compares every ALU response with the oldest one.
//             Counts passes/failures, keeps sticky error flags and captures
//             the first mismatching pair.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             clr_i        - clear counters/flags/capture (queue kept)
//             bus          - request/response snoop (slave modport)
//             pass_cnt_o   - matched responses
//             fail_cnt_o   - mismatch + unexpected + overflow + timeout
//             err_flags_o  - sticky {timeout, overflow, unexpected, mismatch}
//             first_exp_o  - expected value of the first mismatch
//             first_got_o  - received value of the first mismatch
//             idle_o       - no expected result outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2,
    parameter int DEPTH      = 4,
    parameter int MAX_LAT    = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clr_i,
    alu_result_checker_if.slave       bus,
    output logic [CNT_WIDTH-1:0]      pass_cnt_o,
    output logic [CNT_WIDTH-1:0]      fail_cnt_o,
    output logic [3:0]                err_flags_o,
    output logic [2*DATA_WIDTH-1:0]   first_exp_o,
    output logic [2*DATA_WIDTH-1:0]   first_got_o,
    output logic                      idle_o
);
    localparam int c_RW    = 2*DATA_WIDTH;
    localparam int c_AGE_W = $clog2(MAX_LAT + 1);

    logic [c_RW-1:0]      w_exp;
    logic [c_RW-1:0]      w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_cmp_pop;
    logic                 w_unexp;
    logic                 w_timeout;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_overflow;
    logic                 w_match;
    logic                 w_mismatch;
    logic [2:0]           w_fail_inc;
    logic [CNT_WIDTH:0]   w_fail_sum;
    logic [CNT_WIDTH-1:0] w_fail_next;

    logic [CNT_WIDTH-1:0] r_pass;
    logic [CNT_WIDTH-1:0] r_fail;
    logic [3:0]           r_err;
    logic [c_RW-1:0]      r_first_exp;
    logic [c_RW-1:0]      r_first_got;
    logic [c_AGE_W-1:0]   r_age;

    // Prediction is made at issue time, so the queue only holds results.
    assign w_exp = c_RW'(alu_exp_result(c_MAX_DW'(bus.req_data_1_i),
                                        c_MAX_DW'(bus.req_data_2_i),
                                        bus.req_sel_i[1:0],
                                        DATA_WIDTH));

    // Response/queue-state decode. Emptiness is judged before any push in
    // the same cycle, so a response can never match its own request.
    assign w_cmp_pop  = bus.rsp_valid_i && !w_empty;
    assign w_unexp    = bus.rsp_valid_i &&  w_empty;
    assign w_timeout  = !w_empty && !bus.rsp_valid_i &&
                        (r_age == c_AGE_W'(MAX_LAT));
    assign w_pop      = w_cmp_pop || w_timeout;
    assign w_push     = bus.req_valid_i && (!w_full || w_pop);
    assign w_overflow = bus.req_valid_i &&   w_full && !w_pop;
    assign w_match    = w_cmp_pop && (bus.rsp_data_i == w_head);
    assign w_mismatch = w_cmp_pop && (bus.rsp_data_i != w_head);

    alu_chk_fifo #(
        .WIDTH (c_RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_exp),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Several failure sources may coincide; add them all, then saturate.
    assign w_fail_inc  = {2'b00, w_mismatch} + {2'b00, w_unexp} +
                         {2'b00, w_overflow} + {2'b00, w_timeout};
    assign w_fail_sum  = {1'b0, r_fail} + (CNT_WIDTH+1)'(w_fail_inc);
    assign w_fail_next = w_fail_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                               : w_fail_sum[CNT_WIDTH-1:0];

    // Age of the queue head; belongs to the queue, so clr_i leaves it alone.
    always_ff @(posedge clk) begin
        if (rst || w_empty || w_pop) r_age <= '0;
        else                         r_age <= r_age + 1'b1;
    end

    // Statistics. clr_i wins over any event sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_pass      <= '0;
            r_fail      <= '0;
            r_err       <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            if (w_match && (r_pass != {CNT_WIDTH{1'b1}}))
                r_pass <= r_pass + 1'b1;
            r_fail <= w_fail_next;
            if (w_mismatch && !r_err[c_ERR_MISMATCH]) begin
                r_first_exp <= w_head;
                r_first_got <= bus.rsp_data_i;
            end
            if (w_mismatch) r_err[c_ERR_MISMATCH]   <= 1'b1;
            if (w_unexp)    r_err[c_ERR_UNEXPECTED] <= 1'b1;
            if (w_overflow) r_err[c_ERR_OVERFLOW]   <= 1'b1;
            if (w_timeout)  r_err[c_ERR_TIMEOUT]    <= 1'b1;
        end
    end

    assign pass_cnt_o  = r_pass;
    assign fail_cnt_o  = r_fail;
    assign err_flags_o = r_err;
    assign first_exp_o = r_first_exp;
    assign first_got_o = r_first_got;
    assign idle_o      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_checker
//  Purpose  : Directed self-checking bench for alu_result_checker. A table
//             of operations with hand-computed results is streamed with the
//             nominal two-cycle ALU latency, followed by hand-written
//             sequences for mismatch, unexpected, overflow, timeout and
//             mid-stream reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;
    import alu_chk_pkg::*;

    localparam int c_N = 8;

    typedef struct {
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  sel;
        logic [15:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        clr_i;
    logic [15:0] pass_cnt_o;
    logic [15:0] fail_cnt_o;
    logic [3:0]  err_flags_o;
    logic [15:0] first_exp_o;
    logic [15:0] first_got_o;
    logic        idle_o;

    int n_tests;
    int n_fail;
    vec_t vecs [c_N];

    alu_result_checker_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) bus ();

    alu_result_checker #(
        .DATA_WIDTH (8),
        .SEL_WIDTH  (2),
        .DEPTH      (4),
        .MAX_LAT    (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_i),
        .bus         (bus),
        .pass_cnt_o  (pass_cnt_o),
        .fail_cnt_o  (fail_cnt_o),
        .err_flags_o (err_flags_o),
        .first_exp_o (first_exp_o),
        .first_got_o (first_got_o),
        .idle_o      (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one edge; outputs are then observed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [7:0] a,
                             input logic [7:0] b, input logic [1:0] s);
        bus.req_valid_i  = v;
        bus.req_data_1_i = a;
        bus.req_data_2_i = b;
        bus.req_sel_i    = s;
    endtask

    task automatic drive_rsp(input logic v, input logic [15:0] d);
        bus.rsp_valid_i = v;
        bus.rsp_data_i  = d;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clr_i   = 1'b0;
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        drive_rsp(1'b0, 16'h0000);

        vecs[0] = '{op1: 8'd200, op2: 8'd100, sel: c_SEL_ADD, exp: 16'h012C};
        vecs[1] = '{op1: 8'd3,   op2: 8'd5,   sel: c_SEL_SUB, exp: 16'hFFFE};
        vecs[2] = '{op1: 8'd255, op2: 8'd0,   sel: c_SEL_INC, exp: 16'h0100};
        vecs[3] = '{op1: 8'd7,   op2: 8'd9,   sel: c_SEL_NOP, exp: 16'h0000};
        vecs[4] = '{op1: 8'd255, op2: 8'd255, sel: c_SEL_ADD, exp: 16'h01FE};
        vecs[5] = '{op1: 8'd0,   op2: 8'd1,   sel: c_SEL_SUB, exp: 16'hFFFF};
        vecs[6] = '{op1: 8'd0,   op2: 8'd255, sel: c_SEL_SUB, exp: 16'hFF01};
        vecs[7] = '{op1: 8'd0,   op2: 8'd0,   sel: c_SEL_INC, exp: 16'h0001};

        // ---------------- reset state
        repeat (3) step();
        check("rst_pass",  32'(pass_cnt_o),  32'd0);
        check("rst_fail",  32'(fail_cnt_o),  32'd0);
        check("rst_err",   32'(err_flags_o), 32'd0);
        check("rst_idle",  32'(idle_o),      32'd1);
        check("rst_fexp",  32'(first_exp_o), 32'd0);
        check("rst_fgot",  32'(first_got_o), 32'd0);
        rst = 1'b0;

        // ---------------- table: back-to-back ops, responses 2 cycles later
        for (int cyc = 0; cyc < c_N + 2; cyc++) begin
            if (cyc < c_N)
                drive_req(1'b1, vecs[cyc].op1, vecs[cyc].op2, vecs[cyc].sel);
            else
                drive_req(1'b0, 8'd0, 8'd0, 2'b00);
            if (cyc >= 2)
                drive_rsp(1'b1, vecs[cyc-2].exp);
            else
                drive_rsp(1'b0, 16'h0000);
            step();
            if (cyc >= 2) begin
                check($sformatf("vec%0d_pass", cyc - 2), 32'(pass_cnt_o),
                      32'(cyc - 1));
                check($sformatf("vec%0d_fail", cyc - 2), 32'(fail_cnt_o),
                      32'd0);
            end
        end
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        drive_rsp(1'b0, 16'h0000);
        check("vec_idle", 32'(idle_o),      32'd1);
        check("vec_err",  32'(err_flags_o), 32'd0);

        // ---------------- mismatch, first capture kept
        pulse_clr();
        check("clr_pass", 32'(pass_cnt_o), 32'd0);
        drive_req(1'b1, 8'd2, 8'd4, c_SEL_ADD);
        step();
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        drive_rsp(1'b1, 16'h0005);
        step();
        drive_rsp(1'b0, 16'h0000);
        check("mm1_fail", 32'(fail_cnt_o),  32'd1);
        check("mm1_err",  32'(err_flags_o), 32'b0001);
        check("mm1_fexp", 32'(first_exp_o), 32'h0006);
        check("mm1_fgot", 32'(first_got_o), 32'h0005);
        drive_req(1'b1, 8'd1, 8'd1, c_SEL_ADD);
        step();
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        drive_rsp(1'b1, 16'h0009);
        step();
        drive_rsp(1'b0, 16'h0000);
        check("mm2_fail", 32'(fail_cnt_o),  32'd2);
        check("mm2_pass", 32'(pass_cnt_o),  32'd0);
        check("mm2_fexp", 32'(first_exp_o), 32'h0006);
        check("mm2_fgot", 32'(first_got_o), 32'h0005);

        // ---------------- unexpected response, then clear
        pulse_clr();
        check("ux_idle", 32'(idle_o), 32'd1);
        drive_rsp(1'b1, 16'h1234);
        step();
        drive_rsp(1'b0, 16'h0000);
        check("ux_err",  32'(err_flags_o), 32'b0010);
        check("ux_fail", 32'(fail_cnt_o),  32'd1);
        pulse_clr();
        check("clr_err",  32'(err_flags_o), 32'd0);
        check("clr_fail", 32'(fail_cnt_o),  32'd0);
        check("clr_fexp", 32'(first_exp_o), 32'd0);
        check("clr_fgot", 32'(first_got_o), 32'd0);

        // ---------------- overflow then timeouts (pushes at edges E0..E4)
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, 8'(i), 8'd1, c_SEL_ADD);
            step();
        end
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        check("ov_err",  32'(err_flags_o), 32'b0100);
        check("ov_fail", 32'(fail_cnt_o),  32'd1);
        repeat (4) step();                       // E5..E8: head age reaches 8
        check("to_early", 32'(fail_cnt_o), 32'd1);
        step();                                  // E9: first timeout
        check("to1_fail", 32'(fail_cnt_o),  32'd2);
        check("to1_err",  32'(err_flags_o), 32'b1100);
        repeat (26) step();                      // E10..E35
        check("to_idle_early", 32'(idle_o),     32'd0);
        check("to_fail_early", 32'(fail_cnt_o), 32'd4);
        step();                                  // E36: last timeout
        check("to_fail", 32'(fail_cnt_o), 32'd5);
        check("to_idle", 32'(idle_o),     32'd1);

        // ---------------- response on the age == MAX_LAT cycle still compares
        pulse_clr();
        drive_req(1'b1, 8'd10, 8'd3, c_SEL_SUB);
        step();                                  // E0: push, age 0
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        repeat (8) step();                       // E1..E8: age becomes 8
        drive_rsp(1'b1, 16'h0007);
        step();
        drive_rsp(1'b0, 16'h0000);
        check("lat_pass", 32'(pass_cnt_o),  32'd1);
        check("lat_fail", 32'(fail_cnt_o),  32'd0);
        check("lat_err",  32'(err_flags_o), 32'd0);

        // ---------------- reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 8'(i + 1), 8'd2, c_SEL_ADD);
            step();
        end
        drive_req(1'b0, 8'd0, 8'd0, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_idle", 32'(idle_o),     32'd1);
        check("mr_pass", 32'(pass_cnt_o), 32'd0);
        check("mr_fail", 32'(fail_cnt_o), 32'd0);
        drive_rsp(1'b1, 16'h0003);
        step();
        drive_rsp(1'b1, 16'h0004);
        step();
        drive_rsp(1'b0, 16'h0000);
        check("mr_err",   32'(err_flags_o), 32'b0010);
        check("mr_fail2", 32'(fail_cnt_o),  32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
